// File: rtl/connect4_pkg.sv
// Connect 4 turn controller shared definitions.
// Board geometry, player encoding and controller state enums.
package connect4_pkg;

   localparam int COLS      = 7;
   localparam int ROWS      = 6;
   localparam int MAX_MOVES = COLS * ROWS;

   typedef logic player_t;

   typedef enum logic [1:0] {
      GS_PLAYING    = 2'd0,
      GS_WIN_RED    = 2'd1,
      GS_WIN_YELLOW = 2'd2,
      GS_DRAW       = 2'd3
   } game_state_t;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_SELECT,
      ST_DROP,
      ST_CHECK,
      ST_OVER
   } ctrl_state_t;

endpackage

// File: rtl/connect4_turn_controller_button_conditioner.sv
// Button conditioner: 2-FF synchroniser, debounce counter and
// a one-cycle pulse on each rising edge of the debounced level.
module button_conditioner
   import connect4_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          level_q;
   logic          pulse_q;

   // Synchronise, count disagreeing samples, flip level after a full run.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         pulse_q <= 1'b0;
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == LAST) begin
            cnt_q   <= '0;
            level_q <= sync_q[1];
            pulse_q <= sync_q[1];
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/connect4_turn_controller.sv
// Connect 4 game sequencer: conditions buttons, issues drop writes,
// runs the win check and decides win, draw or next turn.
module connect4_turn_controller
   import connect4_pkg::*;
#(
   parameter int      DEBOUNCE_CYCLES = 250000,
   parameter player_t START_PLAYER    = 1'b0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [COLS-1:0]   move_btn,
   input  logic              confirm_btn,
   input  logic              new_game_btn,
   input  logic [3*COLS-1:0] col_heights,
   output logic              clear_req,
   input  logic              clear_ack,
   output logic              wr_req,
   output logic [2:0]        wr_col,
   output logic [2:0]        wr_row,
   output logic              wr_player,
   input  logic              wr_ack,
   output logic              check_start,
   input  logic              check_done,
   input  logic              check_win,
   output logic [2:0]        cursor_col,
   output logic              cur_player,
   output logic [1:0]        game_state,
   output logic              illegal_move
);

   localparam int NBTN = COLS + 2;

   logic [NBTN-1:0] btn_raw;
   logic [NBTN-1:0] btn_p;
   logic [COLS-1:0] col_p;
   logic            conf_p;
   logic            ng_p;

   ctrl_state_t state_q;
   game_state_t gstate_q;
   logic        clear_req_q;
   logic        wr_req_q;
   logic [2:0]  wr_col_q;
   logic [2:0]  wr_row_q;
   player_t     wr_player_q;
   logic        check_start_q;
   logic [2:0]  cursor_q;
   player_t     player_q;
   logic        illegal_q;
   logic [5:0]  moves_q;
   logic        pending_q;

   logic [2:0]  sel_col_d;
   logic [2:0]  sel_h;
   logic        board_full;

   assign btn_raw = {new_game_btn, confirm_btn, move_btn};

   for (genvar g = 0; g < NBTN; g++) begin : g_btn
      button_conditioner #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
         .clock  (clock),
         .reset_n(reset_n),
         .btn_i  (btn_raw[g]),
         .pulse_o(btn_p[g])
      );
   end

   assign {ng_p, conf_p, col_p} = btn_p;

   // Cursor target this cycle (lowest pressed column wins) and its height.
   always_comb begin
      sel_col_d = cursor_q;
      for (int i = COLS - 1; i >= 0; i--) begin
         if (col_p[i]) sel_col_d = 3'(i);
      end
      sel_h = '0;
      for (int i = 0; i < COLS; i++) begin
         if (sel_col_d == 3'(i)) sel_h = col_heights[3*i +: 3];
      end
   end

   assign board_full = (moves_q == 6'(MAX_MOVES));

   // Game sequencing FSM with registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_CLEAR;
         gstate_q      <= GS_PLAYING;
         clear_req_q   <= 1'b1;
         wr_req_q      <= 1'b0;
         wr_col_q      <= '0;
         wr_row_q      <= '0;
         wr_player_q   <= 1'b0;
         check_start_q <= 1'b0;
         cursor_q      <= 3'(COLS / 2);
         player_q      <= START_PLAYER;
         illegal_q     <= 1'b0;
         moves_q       <= '0;
         pending_q     <= 1'b0;
      end else begin
         check_start_q <= 1'b0;
         illegal_q     <= 1'b0;
         unique case (state_q)
            ST_CLEAR: begin
               if (clear_ack) begin
                  clear_req_q <= 1'b0;
                  moves_q     <= '0;
                  player_q    <= START_PLAYER;
                  gstate_q    <= GS_PLAYING;
                  cursor_q    <= 3'(COLS / 2);
                  pending_q   <= 1'b0;
                  state_q     <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (ng_p) begin
                  clear_req_q <= 1'b1;
                  state_q     <= ST_CLEAR;
               end else begin
                  cursor_q <= sel_col_d;
                  if (conf_p) begin
                     if (sel_h < 3'(ROWS)) begin
                        wr_col_q    <= sel_col_d;
                        wr_row_q    <= sel_h;
                        wr_player_q <= player_q;
                        wr_req_q    <= 1'b1;
                        state_q     <= ST_DROP;
                     end else begin
                        illegal_q <= 1'b1;
                     end
                  end
               end
            end
            ST_DROP: begin
               if (ng_p) pending_q <= 1'b1;
               if (wr_ack) begin
                  wr_req_q      <= 1'b0;
                  moves_q       <= moves_q + 6'd1;
                  check_start_q <= 1'b1;
                  state_q       <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (ng_p) pending_q <= 1'b1;
               if (check_done) begin
                  if (check_win) begin
                     gstate_q <= wr_player_q ? GS_WIN_YELLOW : GS_WIN_RED;
                  end else if (board_full) begin
                     gstate_q <= GS_DRAW;
                  end else begin
                     player_q <= ~player_q;
                  end
                  if (pending_q || ng_p) begin
                     clear_req_q <= 1'b1;
                     state_q     <= ST_CLEAR;
                  end else if (check_win || board_full) begin
                     state_q <= ST_OVER;
                  end else begin
                     state_q <= ST_SELECT;
                  end
               end
            end
            ST_OVER: begin
               if (ng_p) begin
                  clear_req_q <= 1'b1;
                  state_q     <= ST_CLEAR;
               end
            end
            default: begin
               clear_req_q <= 1'b1;
               state_q     <= ST_CLEAR;
            end
         endcase
      end
   end

   assign clear_req    = clear_req_q;
   assign wr_req       = wr_req_q;
   assign wr_col       = wr_col_q;
   assign wr_row       = wr_row_q;
   assign wr_player    = wr_player_q;
   assign check_start  = check_start_q;
   assign cursor_col   = cursor_q;
   assign cur_player   = player_q;
   assign game_state   = gstate_q;
   assign illegal_move = illegal_q;

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Bench for connect4_turn_controller: random play checked every
// cycle against a rule-level game model, plus literal checkpoints.
module tb_connect4_turn_controller;

   localparam int N  = 4;
   localparam int NC = 7;
   localparam int NB = NC + 2;
   localparam logic [NB-1:0] CONF = NB'(1) << NC;
   localparam logic [NB-1:0] NG   = NB'(1) << (NC + 1);

   logic            clock        = 1'b0;
   logic            reset_n      = 1'b1;
   logic [NC-1:0]   move_btn     = '0;
   logic            confirm_btn  = 1'b0;
   logic            new_game_btn = 1'b0;
   logic [3*NC-1:0] col_heights;
   logic            clear_ack    = 1'b0;
   logic            wr_ack       = 1'b0;
   logic            check_done   = 1'b0;
   logic            check_win    = 1'b0;
   logic            clear_req, wr_req, wr_player, check_start;
   logic            cur_player, illegal_move;
   logic [2:0]      wr_col, wr_row, cursor_col;
   logic [1:0]      game_state;

   int hgt [NC];
   int vectors = 0;
   int errs    = 0;

   typedef enum int {P_CLEAR, P_PICK, P_WRITE, P_JUDGE, P_DONE} phase_t;
   phase_t m_ph = P_CLEAR;
   bit m_clr, m_wr, m_cs, m_ill, m_wrp, m_pl, m_pend;
   int m_wrc, m_wrr, m_cur, m_gs, m_moves;
   bit h1 [NB];
   bit h2 [NB];
   bit lvl [NB];
   bit mp [NB];
   int run [NB];

   connect4_turn_controller #(
      .DEBOUNCE_CYCLES(N),
      .START_PLAYER   (1'b0)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .move_btn    (move_btn),
      .confirm_btn (confirm_btn),
      .new_game_btn(new_game_btn),
      .col_heights (col_heights),
      .clear_req   (clear_req),
      .clear_ack   (clear_ack),
      .wr_req      (wr_req),
      .wr_col      (wr_col),
      .wr_row      (wr_row),
      .wr_player   (wr_player),
      .wr_ack      (wr_ack),
      .check_start (check_start),
      .check_done  (check_done),
      .check_win   (check_win),
      .cursor_col  (cursor_col),
      .cur_player  (cur_player),
      .game_state  (game_state),
      .illegal_move(illegal_move)
   );

   always #5 clock = ~clock;

   always_comb begin
      col_heights = '0;
      for (int i = 0; i < NC; i++) col_heights[3*i +: 3] = 3'(hgt[i]);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      vectors++;
      errs++;
      $display("FAIL timeout waiting for %s at %0t", nm, $time);
   endtask

   task automatic model_reset();
      m_ph = P_CLEAR;
      m_clr = 1; m_wr = 0; m_cs = 0; m_ill = 0;
      m_wrp = 0; m_pl = 0; m_pend = 0;
      m_wrc = 0; m_wrr = 0; m_cur = NC / 2; m_gs = 0; m_moves = 0;
      for (int b = 0; b < NB; b++) begin
         h1[b] = 0; h2[b] = 0; lvl[b] = 0; mp[b] = 0; run[b] = 0;
      end
   endtask

   // Game rules, applied once per clock using last cycle's press pulses.
   task automatic model_fsm();
      bit ng;
      ng = mp[NB-1];
      m_cs = 0;
      m_ill = 0;
      case (m_ph)
         P_CLEAR: if (clear_ack) begin
            m_clr = 0; m_moves = 0; m_pl = 0; m_gs = 0;
            m_cur = NC / 2; m_pend = 0; m_ph = P_PICK;
         end
         P_PICK: if (ng) begin
            m_ph = P_CLEAR; m_clr = 1;
         end else begin
            for (int i = 0; i < NC; i++) if (mp[i]) begin m_cur = i; break; end
            if (mp[NC]) begin
               if (hgt[m_cur] < 6) begin
                  m_wrc = m_cur; m_wrr = hgt[m_cur]; m_wrp = m_pl;
                  m_wr = 1; m_ph = P_WRITE;
               end else m_ill = 1;
            end
         end
         P_WRITE: begin
            if (ng) m_pend = 1;
            if (wr_ack) begin
               m_wr = 0; m_moves++; m_cs = 1; m_ph = P_JUDGE;
            end
         end
         P_JUDGE: begin
            if (ng) m_pend = 1;
            if (check_done) begin
               if (check_win) begin
                  m_gs = m_wrp ? 2 : 1; m_ph = P_DONE;
               end else if (m_moves == 42) begin
                  m_gs = 3; m_ph = P_DONE;
               end else begin
                  m_pl = !m_pl; m_ph = P_PICK;
               end
               if (m_pend) begin m_ph = P_CLEAR; m_clr = 1; end
            end
         end
         P_DONE: if (ng) begin m_ph = P_CLEAR; m_clr = 1; end
      endcase
   endtask

   task automatic model_step();
      bit raw [NB];
      bit np [NB];
      for (int i = 0; i < NC; i++) raw[i] = move_btn[i];
      raw[NC] = confirm_btn;
      raw[NC+1] = new_game_btn;
      if (!reset_n) begin
         model_reset();
         return;
      end
      model_fsm();
      for (int b = 0; b < NB; b++) begin
         np[b] = 0;
         if (h2[b] != lvl[b]) begin
            run[b]++;
            if (run[b] == N) begin
               lvl[b] = h2[b]; run[b] = 0; np[b] = lvl[b];
            end
         end else run[b] = 0;
      end
      for (int b = 0; b < NB; b++) begin
         h2[b] = h1[b]; h1[b] = raw[b]; mp[b] = np[b];
      end
   endtask

   initial forever begin
      @(posedge clock);
      model_step();
   end

   initial forever begin
      @(negedge clock);
      if (!reset_n) begin
         chk("cyc_clear_req", clear_req, 1);
         chk("cyc_wr_req", wr_req, 0);
         chk("cyc_wr_col", wr_col, 0);
         chk("cyc_wr_row", wr_row, 0);
         chk("cyc_wr_player", wr_player, 0);
         chk("cyc_check_start", check_start, 0);
         chk("cyc_cursor", cursor_col, NC / 2);
         chk("cyc_player", cur_player, 0);
         chk("cyc_game_state", game_state, 0);
         chk("cyc_illegal", illegal_move, 0);
      end else begin
         chk("cyc_clear_req", clear_req, m_clr);
         chk("cyc_wr_req", wr_req, m_wr);
         chk("cyc_wr_col", wr_col, m_wrc);
         chk("cyc_wr_row", wr_row, m_wrr);
         chk("cyc_wr_player", wr_player, m_wrp);
         chk("cyc_check_start", check_start, m_cs);
         chk("cyc_cursor", cursor_col, m_cur);
         chk("cyc_player", cur_player, m_pl);
         chk("cyc_game_state", game_state, m_gs);
         chk("cyc_illegal", illegal_move, m_ill);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [NB-1:0] mask, input int hold, input int rel);
      {new_game_btn, confirm_btn, move_btn} = mask;
      repeat (hold) tick();
      {new_game_btn, confirm_btn, move_btn} = '0;
      repeat (rel) tick();
   endtask

   task automatic wait_wr_req(output bit ok);
      ok = 0;
      for (int t = 0; t < 60; t++) begin
         if (wr_req) begin ok = 1; break; end
         tick();
      end
      if (!ok) timeout("wr_req");
   endtask

   task automatic serve(input bit win);
      bit ok;
      wait_wr_req(ok);
      if (!ok) return;
      repeat ($urandom_range(0, 2)) tick();
      wr_ack = 1;
      hgt[m_wrc]++;
      tick();
      wr_ack = 0;
      ok = 0;
      for (int t = 0; t < 10; t++) begin
         if (check_start) begin ok = 1; break; end
         tick();
      end
      if (!ok) begin timeout("check_start"); return; end
      repeat ($urandom_range(0, 2)) tick();
      check_done = 1;
      check_win = win;
      tick();
      check_done = 0;
      check_win = 0;
   endtask

   task automatic do_clear();
      bit ok;
      ok = 0;
      for (int t = 0; t < 60; t++) begin
         if (clear_req) begin ok = 1; break; end
         tick();
      end
      if (!ok) begin timeout("clear_req"); return; end
      repeat ($urandom_range(0, 3)) tick();
      clear_ack = 1;
      for (int i = 0; i < NC; i++) hgt[i] = 0;
      tick();
      clear_ack = 0;
   endtask

   task automatic move(input int c, input bit together, input bit win);
      if (together) press((NB'(1) << c) | CONF, 8, 8);
      else begin
         press(NB'(1) << c, 8, 8);
         press(CONF, 8, 8);
      end
      serve(win);
   endtask

   initial begin
      #400000;
      errs++;
      $display("FAIL watchdog expired at %0t", $time);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      bit ok;
      int cnt;
      bit saw;
      int c;
      #2 reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (3) tick();
      chk("clear_req_before_ack", clear_req, 1);
      clear_ack = 1;
      tick();
      clear_ack = 0;
      chk("clear_req_after_ack", clear_req, 0);
      chk("state_after_clear", game_state, 0);
      chk("player_after_clear", cur_player, 0);
      chk("cursor_after_clear", cursor_col, 3);

      press(NB'(1) << 5, 8, 8);
      chk("cursor_col5", cursor_col, 5);
      press(CONF, 8, 8);
      wait_wr_req(ok);
      chk("first_wr_req", wr_req, 1);
      chk("first_wr_col", wr_col, 5);
      chk("first_wr_row", wr_row, 0);
      chk("first_wr_player", wr_player, 0);
      serve(0);
      chk("player_after_move1", cur_player, 1);

      press(NB'(1) << 1, 3, 8);
      chk("glitch_cursor", cursor_col, 5);
      press(NB'(1) << 1, 8, 8);
      chk("hold_cursor", cursor_col, 1);

      hgt[2] = 6;
      press(NB'(1) << 2, 8, 8);
      cnt = 0;
      saw = 0;
      confirm_btn = 1;
      for (int k = 0; k < 16; k++) begin
         if (k == 8) confirm_btn = 0;
         tick();
         if (illegal_move) cnt++;
         if (wr_req) saw = 1;
      end
      chk("illegal_pulse_len", cnt, 1);
      chk("illegal_no_wr", saw, 0);
      hgt[2] = 0;

      press(NB'(1) << 1, 8, 8);
      press(CONF, 8, 8);
      wait_wr_req(ok);
      chk("yellow_wr_player", wr_player, 1);
      serve(1);
      chk("yellow_win_state", game_state, 2);

      saw = 0;
      confirm_btn = 1;
      for (int k = 0; k < 16; k++) begin
         if (k == 8) confirm_btn = 0;
         tick();
         if (wr_req) saw = 1;
      end
      chk("over_no_wr", saw, 0);

      press(NG, 8, 8);
      do_clear();
      chk("newgame_state", game_state, 0);

      for (int k = 0; k < 30; k++) begin
         move_btn = NC'($urandom_range(0, 127));
         repeat ($urandom_range(1, 9)) tick();
         move_btn = '0;
         case ($urandom_range(0, 5))
            0: wr_ack = 1;
            1: check_done = 1;
            2: clear_ack = 1;
            default: ;
         endcase
         tick();
         wr_ack = 0;
         check_done = 0;
         clear_ack = 0;
         repeat (7) tick();
      end
      chk("stray_ack_no_wr", wr_req, 0);

      for (int i = 0; i < 42; i++) begin
         chk("turn_player", cur_player, i % 2);
         do c = $urandom_range(0, NC - 1); while (hgt[c] >= 6);
         move(c, 1'($urandom_range(0, 1)), 0);
      end
      chk("draw_state", game_state, 3);

      press(NG, 8, 8);
      do_clear();

      press(NB'(1) << 4, 8, 8);
      press(CONF, 8, 8);
      wait_wr_req(ok);
      press(NG, 8, 8);
      chk("ng_drop_hold", wr_req, 1);
      serve(0);
      chk("ng_then_clear", clear_req, 1);
      do_clear();

      press(NB'(1) << 0, 8, 8);
      press(CONF, 8, 8);
      wait_wr_req(ok);
      reset_n = 0;
      #1;
      chk("rst_drops_wr_req", wr_req, 0);
      chk("rst_clear_req", clear_req, 1);
      tick();
      tick();
      reset_n = 1;
      for (int i = 0; i < NC; i++) hgt[i] = 0;
      do_clear();
      chk("rst_cursor", cursor_col, 3);
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
